// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Circular instruction queue between the I-side (post address translation)
// and decode. Accepts packets of up to FETCH_WIDTH instructions per cycle and
// presents the ISSUE_WIDTH oldest entries to decode, which consumes a
// variable number of them each cycle. A redirect flush discards everything.
//
// Ports
//   clk              clock, all state updates on the rising edge
//   reset            synchronous active-high reset (same effect as flush)
//   flush            redirect: drop all queued entries and the same-cycle packet
//   in_valid         fetch packet present
//   in_ready         room for a full FETCH_WIDTH packet (from registered count)
//   in_pc            pc of slot 0; slot i has pc = in_pc + 4*i
//   in_mask          per-slot valid, contiguous from bit 0
//   in_instr         raw instructions, slot i at [32i+31:32i]
//   in_tlb_invalid   packet-wide I-TLB invalid
//   in_tlb_refill    packet-wide I-TLB refill
//   in_tlb_modified  packet-wide I-TLB modified
//   out_valid        thermometer, bit k = (count > k)
//   out_pc           pc of entry head+k
//   out_pcplus4      pc+4 of entry head+k
//   out_instr        instruction of entry head+k
//   out_exc          {addr_err, tlb_invalid, tlb_modified, tlb_refill} per entry
//   out_take         entries consumed by decode this cycle
//   count            current occupancy
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [31:0]                        in_pc,
  input  logic [FETCH_WIDTH-1:0]             in_mask,
  input  logic [32*FETCH_WIDTH-1:0]          in_instr,
  input  logic                               in_tlb_invalid,
  input  logic                               in_tlb_refill,
  input  logic                               in_tlb_modified,
  output logic [ISSUE_WIDTH-1:0]             out_valid,
  output logic [32*ISSUE_WIDTH-1:0]          out_pc,
  output logic [32*ISSUE_WIDTH-1:0]          out_pcplus4,
  output logic [32*ISSUE_WIDTH-1:0]          out_instr,
  output logic [4*ISSUE_WIDTH-1:0]           out_exc,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   out_take,
  output logic [$clog2(DEPTH+1)-1:0]         count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(ISSUE_WIDTH+1);

  // Highest occupancy at which a full packet still fits.
  localparam logic [CW-1:0] READY_LIMIT = CW'(DEPTH - FETCH_WIDTH);
  localparam logic [CW-1:0] ISSUE_MAX   = CW'(ISSUE_WIDTH);

  // Queue state
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Entry storage
  logic [31:0] pc_q     [DEPTH];
  logic [31:0] pcplus4_q[DEPTH];
  logic [31:0] instr_q  [DEPTH];
  logic [3:0]  exc_q    [DEPTH];

  // Incoming packet decode
  logic          exc_any_s;
  logic          addr_err_s;
  logic [CW-1:0] mask_cnt_s;
  logic          enq_s;
  logic [CW-1:0] n_enq_s;
  logic [CW-1:0] take_s;
  logic [CW-1:0] take_cnt_s;
  logic [CW-1:0] n_deq_s;
  logic [31:0]   slot_pc_s   [FETCH_WIDTH];
  logic [31:0]   slot_instr_s[FETCH_WIDTH];
  logic [3:0]    slot_exc_s;
  logic [PW-1:0] rd_idx_s    [ISSUE_WIDTH];

  // Acceptance depends only on registered occupancy, never on same-cycle dequeue.
  always_comb begin
    in_ready = (count_q <= READY_LIMIT);
  end

  // Per-slot derivation of pc, instruction and exception flags.
  always_comb begin
    // Every slot pc shares the low two bits of in_pc, so slot 0 decides alignment.
    addr_err_s = |in_pc[1:0];
    exc_any_s  = addr_err_s | in_tlb_invalid | in_tlb_refill | in_tlb_modified;
    slot_exc_s = {addr_err_s, in_tlb_invalid, in_tlb_modified, in_tlb_refill};
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_pc_s[i] = in_pc + 32'(4 * i);
      if (exc_any_s) begin
        // Faulting fetch becomes a single nop carrying the exception flags.
        slot_instr_s[i] = 32'h0000_0000;
      end else begin
        slot_instr_s[i] = in_instr[32*i +: 32];
      end
    end
  end

  // Number of slots written this cycle.
  always_comb begin
    mask_cnt_s = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      mask_cnt_s = mask_cnt_s + CW'(in_mask[i]);
    end
    enq_s = in_valid & in_ready & ~flush;
    if (!enq_s) begin
      n_enq_s = '0;
    end else if (exc_any_s) begin
      // Truncate to slot 0 regardless of in_mask.
      n_enq_s = CW'(1);
    end else begin
      n_enq_s = mask_cnt_s;
    end
  end

  // Dequeue count, clamped to what is actually presented so that an
  // illegal out_take can never underflow the queue.
  always_comb begin
    take_s = CW'(out_take);
    if (take_s > count_q) begin
      take_cnt_s = count_q;
    end else begin
      take_cnt_s = take_s;
    end
    if (take_cnt_s > ISSUE_MAX) begin
      n_deq_s = ISSUE_MAX;
    end else begin
      n_deq_s = take_cnt_s;
    end
  end

  // Next-state pointers and occupancy; flush wins over enqueue and dequeue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers wrap naturally at PW bits since DEPTH is a power of two.
      head_d  = head_q + PW'(n_deq_s);
      tail_d  = tail_q + PW'(n_enq_s);
      count_d = count_q + n_enq_s - n_deq_s;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage writes at tail, tail+1, ... in slot order. Stale contents
  // are never observable because outputs are masked by occupancy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!reset && (CW'(i) < n_enq_s)) begin
        pc_q     [tail_q + PW'(i)] <= slot_pc_s[i];
        pcplus4_q[tail_q + PW'(i)] <= slot_pc_s[i] + 32'd4;
        instr_q  [tail_q + PW'(i)] <= slot_instr_s[i];
        exc_q    [tail_q + PW'(i)] <= slot_exc_s;
      end
    end
  end

  // Read indices for the presented window.
  always_comb begin
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      rd_idx_s[k] = head_q + PW'(k);
    end
  end

  // Decode-facing outputs; data is forced to zero for slots beyond occupancy.
  always_comb begin
    out_valid   = '0;
    out_pc      = '0;
    out_pcplus4 = '0;
    out_instr   = '0;
    out_exc     = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (count_q > CW'(k)) begin
        out_valid[k]          = 1'b1;
        out_pc[32*k +: 32]      = pc_q[rd_idx_s[k]];
        out_pcplus4[32*k +: 32] = pcplus4_q[rd_idx_s[k]];
        out_instr[32*k +: 32]   = instr_q[rd_idx_s[k]];
        out_exc[4*k +: 4]       = exc_q[rd_idx_s[k]];
      end else begin
        out_valid[k] = 1'b0;
      end
    end
  end

  // Occupancy output.
  always_comb begin
    count = count_q;
  end

  fetch_queue_chk #(
    .DEPTH (DEPTH),
    .TW    (TW),
    .CW    (CW)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .out_take (out_take),
    .count    (count_q)
  );

endmodule

// ---------------------------------------------------------------------------
// fetch_queue_chk
//
// Simulation-only protocol checks for fetch_queue.
//
// Ports
//   clk, reset, flush  as on fetch_queue
//   out_take           decode consumption request
//   count              registered occupancy
// ---------------------------------------------------------------------------
module fetch_queue_chk #(
  parameter int DEPTH = 8,
  parameter int TW    = 2,
  parameter int CW    = 4
) (
  input logic          clk,
  input logic          reset,
  input logic          flush,
  input logic [TW-1:0] out_take,
  input logic [CW-1:0] count
);

  // Decode may not take more entries than are valid (flush ignores out_take).
  a_take_legal: assert property (@(posedge clk) disable iff (reset || flush)
    (int'(out_take) <= int'(count)));

  // Occupancy is bounded by the storage size.
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    (int'(count) <= DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// queue-based model of the fetch queue.
module tb_fetch_queue;

  localparam int FW = 2;
  localparam int IW = 2;
  localparam int DP = 8;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [31:0] in_pc;
  logic [1:0]  in_mask;
  logic [63:0] in_instr;
  logic        in_tlb_invalid, in_tlb_refill, in_tlb_modified;
  logic [1:0]  out_valid;
  logic [63:0] out_pc, out_pcplus4, out_instr;
  logic [7:0]  out_exc;
  logic [1:0]  out_take;
  logic [3:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  exc;
  } ent_t;

  ent_t mq[$];

  always #5 clk = ~clk;

  fetch_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_pc(in_pc), .in_mask(in_mask), .in_instr(in_instr),
    .in_tlb_invalid(in_tlb_invalid), .in_tlb_refill(in_tlb_refill),
    .in_tlb_modified(in_tlb_modified), .out_valid(out_valid), .out_pc(out_pc),
    .out_pcplus4(out_pcplus4), .out_instr(out_instr), .out_exc(out_exc),
    .out_take(out_take), .count(count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every observable output against the model.
  task automatic check_outputs();
    int sz;
    sz = mq.size();
    chk("count", 64'(count), 64'(sz));
    chk("in_ready", 64'(in_ready), 64'((DP - sz) >= FW));
    for (int k = 0; k < IW; k++) begin
      if (k < sz) begin
        chk("out_valid", 64'(out_valid[k]), 64'(1));
        chk("out_pc", 64'(out_pc[32*k +: 32]), 64'(mq[k].pc));
        chk("out_pcplus4", 64'(out_pcplus4[32*k +: 32]), 64'(mq[k].pc + 32'd4));
        chk("out_instr", 64'(out_instr[32*k +: 32]), 64'(mq[k].instr));
        chk("out_exc", 64'(out_exc[4*k +: 4]), 64'(mq[k].exc));
      end else begin
        chk("out_valid_off", 64'(out_valid[k]), 64'(0));
        chk("out_data_zero", {out_pc[32*k +: 32], out_instr[32*k +: 32]}, 64'(0));
        chk("out_p4_exc_zero", {28'(0), out_exc[4*k +: 4], out_pcplus4[32*k +: 32]}, 64'(0));
      end
    end
  endtask

  // Reference behaviour for one clock edge, from the current inputs.
  task automatic model_apply();
    int   sz, ndeq;
    bit   rdy;
    logic [3:0] exc;
    ent_t e;
    if (reset || flush) begin
      mq.delete();
    end else begin
      sz   = mq.size();
      rdy  = (DP - sz) >= FW;
      ndeq = (int'(out_take) < sz) ? int'(out_take) : sz;
      for (int j = 0; j < ndeq; j++) void'(mq.pop_front());
      if (in_valid && rdy) begin
        exc = {|in_pc[1:0], in_tlb_invalid, in_tlb_modified, in_tlb_refill};
        if (exc != 4'b0) begin
          e.pc = in_pc; e.instr = 32'h0; e.exc = exc;
          mq.push_back(e);
        end else begin
          for (int i = 0; i < FW; i++) begin
            if (in_mask[i]) begin
              e.pc = in_pc + 32'(4 * i); e.instr = in_instr[32*i +: 32]; e.exc = 4'b0;
              mq.push_back(e);
            end
          end
        end
      end
    end
  endtask

  // One clock: model update, edge, then compare at the falling edge.
  task automatic cycle();
    model_apply();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = 32'h0; in_mask = 2'b00;
    in_instr = 64'h0; in_tlb_invalid = 1'b0; in_tlb_refill = 1'b0;
    in_tlb_modified = 1'b0; out_take = 2'd0;
  endtask

  task automatic pkt(input logic [31:0] pc, input logic [1:0] mask, input logic [1:0] take);
    idle();
    in_valid = 1'b1; in_pc = pc; in_mask = mask; out_take = take;
    in_instr = {pc ^ 32'hA5A5_0001, pc ^ 32'h5A5A_0000};
    cycle();
  endtask

  task automatic do_flush();
    idle(); flush = 1'b1; cycle(); idle();
  endtask

  initial begin
    logic [31:0] next_pc;
    int sz, tk;
    idle();
    reset = 1'b1;
    cycle();
    cycle();
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    idle();

    // First packet
    idle();
    in_valid = 1'b1; in_pc = 32'hBFC0_0000; in_mask = 2'b11;
    in_instr = {32'h0010_0093, 32'h0000_0013};
    cycle();
    idle();
    chk("first_valid", 64'(out_valid), 64'(2'b11));
    chk("first_pc", out_pc, 64'hBFC0_0004_BFC0_0000);
    chk("first_p4_slot1", 64'(out_pcplus4[63:32]), 64'hBFC0_0008);
    chk("first_instr", out_instr, 64'h0010_0093_0000_0013);
    chk("first_count", 64'(count), 64'(2));

    // Fill to full
    do_flush();
    for (int p = 0; p < 4; p++) pkt(32'h0000_1000 + 32'(8 * p), 2'b11, 2'd0);
    chk("full_count", 64'(count), 64'(8));
    chk("full_ready", 64'(in_ready), 64'(0));
    pkt(32'h0000_1020, 2'b11, 2'd0);
    chk("full_hold", 64'(count), 64'(8));
    idle(); out_take = 2'd1; cycle();
    chk("take1_count", 64'(count), 64'(7));
    chk("take1_ready", 64'(in_ready), 64'(0));
    chk("take1_head", 64'(out_pc[31:0]), 64'h0000_1004);
    idle(); out_take = 2'd2; cycle();
    chk("take2_count", 64'(count), 64'(5));
    chk("take2_ready", 64'(in_ready), 64'(1));

    // Wrap-around with steady consumption
    do_flush();
    next_pc = 32'h0000_2000;
    for (int j = 0; j < 20; j++) begin
      sz = mq.size();
      tk = (sz < 2) ? sz : 2;
      if (tk > 0) chk("wrap_seq0", 64'(out_pc[31:0]), 64'(next_pc));
      if (tk > 1) chk("wrap_seq1", 64'(out_pc[63:32]), 64'(next_pc + 32'd4));
      next_pc = next_pc + 32'(4 * tk);
      pkt(32'h0000_2000 + 32'(8 * j), 2'b11, 2'(tk));
      chk("wrap_cnt_le4", 64'(count <= 4'd4), 64'(1));
    end

    // Misaligned pc: one nop entry with addr_err
    do_flush();
    pkt(32'h0040_0002, 2'b11, 2'd0);
    chk("mis_count", 64'(count), 64'(1));
    chk("mis_exc", 64'(out_exc[3:0]), 64'(4'b1000));
    chk("mis_instr", 64'(out_instr[31:0]), 64'(0));
    do_flush();
    idle(); in_valid = 1'b1; in_pc = 32'h0040_0010; in_mask = 2'b11;
    in_instr = 64'hDEAD_BEEF_CAFE_F00D; in_tlb_refill = 1'b1;
    cycle(); idle();
    chk("refill_count", 64'(count), 64'(1));
    chk("refill_exc", 64'(out_exc[3:0]), 64'(4'b0001));
    chk("refill_instr", 64'(out_instr[31:0]), 64'(0));

    // Flush with a simultaneous packet and take
    do_flush();
    pkt(32'h0000_3000, 2'b11, 2'd0);
    pkt(32'h0000_3008, 2'b11, 2'd0);
    pkt(32'h0000_3010, 2'b01, 2'd0);
    chk("pre_flush_count", 64'(count), 64'(5));
    idle(); flush = 1'b1; in_valid = 1'b1; in_pc = 32'h0000_3100; in_mask = 2'b11;
    out_take = 2'd2;
    cycle(); idle();
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_valid", 64'(out_valid), 64'(0));
    pkt(32'h8000_0100, 2'b11, 2'd0);
    chk("post_flush_pc", 64'(out_pc[31:0]), 64'h8000_0100);

    // Single-slot enqueue while taking one
    do_flush();
    pkt(32'h0000_4000, 2'b11, 2'd0);
    pkt(32'h0000_4008, 2'b01, 2'd0);
    chk("mix_pre_count", 64'(count), 64'(3));
    pkt(32'h0000_4100, 2'b01, 2'd1);
    chk("mix_count", 64'(count), 64'(3));
    chk("mix_head", 64'(out_pc[31:0]), 64'h0000_4004);
    idle(); out_take = 2'd2; cycle();
    chk("mix_new_at_tail", 64'(out_pc[31:0]), 64'h0000_4100);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      sz = mq.size();
      reset    = ($urandom_range(0, 199) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       in_mask = 2'b00;
        1:       in_mask = 2'b01;
        default: in_mask = 2'b11;
      endcase
      in_pc = {$urandom()} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) in_pc[1:0] = 2'($urandom_range(1, 3));
      in_instr = {$urandom(), $urandom()};
      in_tlb_invalid  = ($urandom_range(0, 29) == 0);
      in_tlb_refill   = ($urandom_range(0, 29) == 0);
      in_tlb_modified = ($urandom_range(0, 29) == 0);
      out_take = 2'($urandom_range(0, (sz < 2) ? sz : 2));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-instruction fetch stage. Accepts fetch packets of up to FETCH_WIDTH instructions per cycle from the I-side (after address translation) and buffers them in a circular instruction queue.
- Each queue entry holds pc, pcplus4, instruction and exception flags.
- Presents up to ISSUE_WIDTH oldest entries to decode per cycle. Decode consumes a variable count.
- Decouples I-cache latency from decode stalls. Supports flush on redirect.

Parameters:
- FETCH_WIDTH, 2, instructions per incoming packet (1..4)
- ISSUE_WIDTH, 2, entries presented to decode per cycle (1..4)
- DEPTH, 8, queue entries; power of 2, ≥ 2*max(FETCH_WIDTH, ISSUE_WIDTH)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  redirect; discard all queued entries
- in_valid  in  1  packet present
- in_ready  out  1  queue can accept a full packet
- in_pc  in  32  pc of slot 0; slot i pc = in_pc + 4*i
- in_mask  in  FETCH_WIDTH  per-slot valid; contiguous from bit 0
- in_instr  in  32*FETCH_WIDTH  raw instructions; slot i at bits [32i+31:32i]
- in_tlb_invalid  in  1  packet-wide I-TLB invalid
- in_tlb_refill  in  1  packet-wide I-TLB refill
- in_tlb_modified  in  1  packet-wide I-TLB modified
- out_valid  out  ISSUE_WIDTH  thermometer: bit k = (count > k)
- out_pc  out  32*ISSUE_WIDTH  pc of entry head+k
- out_pcplus4  out  32*ISSUE_WIDTH  pc+4 of entry head+k
- out_instr  out  32*ISSUE_WIDTH  instruction of entry head+k
- out_exc  out  4*ISSUE_WIDTH  {addr_err, tlb_invalid, tlb_modified, tlb_refill} per entry
- out_take  in  $clog2(ISSUE_WIDTH+1)  entries consumed this cycle
- count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (synchronous, active-high): head = tail = count = 0. Results: out_valid = 0, in_ready = 1, all out_* data = 0 while invalid.
- Storage is a register array. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is held separately.
- in_ready = (DEPTH - count ≥ FETCH_WIDTH).
  - Combinational from registered count only; it does not credit same-cycle dequeue.
  - It does not depend on in_valid.
- Enqueue occurs when in_valid & in_ready & !flush.
  - Slots are written at tail, tail+1, … in slot order.
  - Number of slots written n = popcount(in_mask). in_mask = 0 enqueues nothing.
  - Entries become visible on out_* the next cycle (1-cycle latency).
- Per-entry derivation:
  - pc = in_pc + 4*i
  - pcplus4 = pc + 4
  - addr_err = |pc[1:0]
  - tlb flags copied from the packet
- Exception truncation: if addr_err(slot 0) or any tlb flag is set, only slot 0 is enqueued, with its instr forced to 32'h0 (nop), regardless of in_mask[0]. Remaining slots are dropped.
- Dequeue:
  - out_* slot k shows entry (head+k) mod DEPTH.
  - head advances by out_take at the clock edge.
  - out_take > popcount(out_valid) is illegal; a simulation assertion fires and the RTL clamps out_take to count.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq. Both are applied in the same edge; wrap is handled on both pointers.
- flush has priority over everything.
  - Next cycle: head = tail = count = 0 and out_valid = 0.
  - The same-cycle enqueue is discarded and out_take is ignored.
  - in_ready during the flush cycle still reflects the pre-flush count.
- reset asserted mid-operation behaves identically to flush.
- Full: when count > DEPTH - FETCH_WIDTH, in_ready = 0 and an asserted in_valid is held off; no entry is overwritten.
- Empty: out_valid = 0; out_take must be 0.
- Width rules: pc arithmetic is 32-bit modulo 2^32; count never exceeds DEPTH.

Test Plan:
- Reset, then in_pc=32'hBFC0_0000, mask=2'b11, instrs A,B.
  - Next cycle: out_valid=2'b11, out_pc={BFC0_0004, BFC0_0000}, out_pcplus4 slot1 = BFC0_0008, count=2.
- Fill with out_take=0 and 4 packets of 2 (DEPTH=8).
  - After the 4th: count=8, in_ready=0.
  - A 5th in_valid is ignored (count stays 8).
  - out_take=1 then gives count=7, still in_ready=0; out_take=2 gives in_ready=1.
- Wrap-around: 20 packets with steady out_take=2.
  - out_pc increments by 4 each entry across pointer wrap with no gap or duplicate; count oscillates ≤ 4.
- in_pc=32'h0040_0002, mask=2'b11.
  - Exactly one entry enqueued: addr_err=1, instr=0, count=1.
  - Same for in_tlb_refill=1 with an aligned pc: one entry, exc=4'b0001.
- count=5, then flush with a simultaneous valid packet and out_take=2.
  - Next cycle: count=0, out_valid=0.
  - The following packet at pc 32'h8000_0100 appears at out slot 0.
- mask=2'b01 with simultaneous out_take=1 at count=3: count stays 3; the new entry lands at the old tail.
